// File: rtl/koopa_anim_controller.sv
// Animation scheduler for one Koopa fighter. It selects the active per-move FSM
// and issues its restart pulse. It also times the locked moves (attack, hitstun).
module koopa_anim_controller #(
    parameter int ATTACK_TICKS  = 16,
    parameter int HITSTUN_TICKS = 12,
    parameter int HIT_START     = 5,
    parameter int HIT_END       = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       anim_tick,
    input  logic       move_l,
    input  logic       move_r,
    input  logic       atk_btn,
    input  logic       airborne,
    input  logic       hit_in,
    output logic [2:0] anim_sel,
    output logic       anim_rst,
    output logic       facing,
    output logic       busy,
    output logic       hitbox_en
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WALK    = 3'd1,
        S_JUMP    = 3'd2,
        S_ATTACK  = 3'd3,
        S_HITSTUN = 3'd4
    } state_t;

    state_t     state_q, state_d, free_state;
    logic [4:0] tick_cnt_q, tick_cnt_d, lock_last;
    logic       atk_prev_q;
    logic       rst_pend_q, rst_pend_d;
    logic       facing_q;
    logic [2:0] anim_sel_q;
    logic       anim_rst_q;
    logic       hitbox_en_q;
    logic       atk_rise;
    logic       locked;
    logic       hitbox_live;

    assign atk_rise    = atk_btn & ~atk_prev_q;
    assign locked      = (state_q == S_ATTACK) || (state_q == S_HITSTUN);
    assign hitbox_live = (state_q == S_ATTACK) && (tick_cnt_q >= 5'(HIT_START))
                         && (tick_cnt_q <= 5'(HIT_END));

    always_comb begin
        free_state = S_IDLE;
        if (airborne) begin
            free_state = S_JUMP;
        end else if (move_l ^ move_r) begin
            free_state = S_WALK;
        end

        lock_last  = (state_q == S_ATTACK) ? 5'(ATTACK_TICKS - 1) : 5'(HITSTUN_TICKS - 1);
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;

        if (hit_in) begin
            state_d    = S_HITSTUN;
            tick_cnt_d = 5'd0;
        end else if (atk_rise && !locked) begin
            state_d    = S_ATTACK;
            tick_cnt_d = 5'd0;
        end else if (locked) begin
            if (anim_tick) begin
                // The last tick of a lock releases straight into the free-state choice.
                if (tick_cnt_q == lock_last) begin
                    state_d    = free_state;
                    tick_cnt_d = 5'd0;
                end else begin
                    tick_cnt_d = tick_cnt_q + 5'd1;
                end
            end
        end else begin
            state_d = free_state;
        end

        // A hit always restarts the hitstun animation, even when already in hitstun.
        rst_pend_d = (state_d != state_q) || hit_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= 5'd0;
            atk_prev_q  <= 1'b0;
            rst_pend_q  <= 1'b0;
            facing_q    <= 1'b0;
            anim_sel_q  <= 3'd0;
            anim_rst_q  <= 1'b1;
            hitbox_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            atk_prev_q  <= atk_btn;
            rst_pend_q  <= rst_pend_d;
            anim_sel_q  <= state_q;
            anim_rst_q  <= rst_pend_q;
            hitbox_en_q <= hitbox_live;
            if (state_q == S_WALK) begin
                facing_q <= move_l;
            end
        end
    end

    assign anim_sel  = anim_sel_q;
    assign anim_rst  = anim_rst_q;
    assign facing    = facing_q;
    assign busy      = locked;
    assign hitbox_en = hitbox_en_q;

endmodule
